// File: rtl/mips_defs_pkg.sv
// Shared MIPS encodings: opcode/funct values and the ALU control encodings
// consumed by the EX stage.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  localparam logic [3:0] ALU_OP_NONE = 4'd0;
  localparam logic [3:0] ALU_OP_OR_I = 4'd1;
  localparam logic [3:0] ALU_OP_ADD  = 4'd2;
  localparam logic [3:0] ALU_OP_SUB  = 4'd3;
  localparam logic [3:0] ALU_OP_LUI  = 4'd4;
  localparam logic [3:0] ALU_OP_AND  = 4'd5;
  localparam logic [3:0] ALU_OP_OR   = 4'd6;
  localparam logic [3:0] ALU_OP_SLT  = 4'd7;

  localparam logic [1:0] ALU_SRC_REG  = 2'd0;
  localparam logic [1:0] ALU_SRC_ZEXT = 2'd1;
  localparam logic [1:0] ALU_SRC_SEXT = 2'd2;

  localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/id_ex_decode.sv
// EX-side decode of the instruction held in the ID->EX register; all outputs
// are forced to zero when the held entry is not valid.
module id_ex_decode
  import mips_defs::*;
(
  input  logic [31:0] instr,
  input  logic        valid,
  output logic [3:0]  alu_op,
  output logic [1:0]  alu_src,
  output logic [4:0]  wb_addr,
  output logic        wb_en
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_bits;

  assign opcode      = instr[31:26];
  assign rt          = instr[20:16];
  assign rd          = instr[15:11];
  assign funct       = instr[5:0];
  assign unused_bits = ^{instr[25:21], instr[10:6]};

  always_comb begin
    alu_op  = ALU_OP_NONE;
    alu_src = ALU_SRC_REG;
    wb_addr = 5'd0;
    if (valid) begin
      unique case (opcode)
        OP_RTYPE: begin
          unique case (funct)
            FN_ADDU: begin alu_op = ALU_OP_ADD; wb_addr = rd; end
            FN_SUBU: begin alu_op = ALU_OP_SUB; wb_addr = rd; end
            FN_AND:  begin alu_op = ALU_OP_AND; wb_addr = rd; end
            FN_OR:   begin alu_op = ALU_OP_OR;  wb_addr = rd; end
            FN_SLT:  begin alu_op = ALU_OP_SLT; wb_addr = rd; end
            FN_JALR: wb_addr = rd;
            default: ;
          endcase
        end
        OP_ORI:  begin alu_op = ALU_OP_OR_I; alu_src = ALU_SRC_ZEXT; wb_addr = rt; end
        OP_LUI:  begin alu_op = ALU_OP_LUI;  alu_src = ALU_SRC_ZEXT; wb_addr = rt; end
        OP_ADDI: begin alu_op = ALU_OP_ADD;  alu_src = ALU_SRC_SEXT; wb_addr = rt; end
        OP_LW:   begin alu_op = ALU_OP_ADD;  alu_src = ALU_SRC_SEXT; wb_addr = rt; end
        OP_SW:   begin alu_op = ALU_OP_ADD;  alu_src = ALU_SRC_SEXT; end
        OP_JAL:  wb_addr = REG_RA;
        default: ;
      endcase
    end
  end

  // Writes to $0 are architecturally discarded, so they never raise wb_en.
  assign wb_en = valid & (wb_addr != 5'd0);

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID->EX pipeline register with valid/ready handshake, stall, flush and a
// saturating Tnew countdown, followed by decode of the held instruction.
module id_ex_pipe_stage
  import mips_defs::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 2,
  parameter int TNEW_W  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_instr,
  input  logic [NUM_SRC*DATA_W-1:0] in_src,
  input  logic [DATA_W-1:0]         in_pc,
  input  logic [TNEW_W-1:0]         in_tnew,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_instr,
  output logic [NUM_SRC*DATA_W-1:0] out_src,
  output logic [DATA_W-1:0]         out_pc,
  output logic [TNEW_W-1:0]         out_tnew,
  output logic [3:0]                alu_op,
  output logic [1:0]                alu_src,
  output logic [4:0]                wb_addr,
  output logic                      wb_en
);

  // Handshake: a transfer happens on an edge where valid & ready are both 1 on
  // that side; in_ready never depends on in_valid, and a flushed incoming
  // transfer still completes upstream but is dropped here.
  logic                      valid_q, valid_d;
  logic [31:0]               instr_q, instr_d;
  logic [NUM_SRC*DATA_W-1:0] src_q, src_d;
  logic [DATA_W-1:0]         pc_q, pc_d;
  logic [TNEW_W-1:0]         tnew_q, tnew_d;
  logic                      load;
  logic                      drain;

  assign in_ready = ~valid_q | out_ready;
  assign load     = in_valid & in_ready & ~flush;
  assign drain    = valid_q & out_ready;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    src_d   = src_q;
    pc_d    = pc_q;
    tnew_d  = tnew_q;
    if (flush) begin
      valid_d = 1'b0;
      instr_d = '0;
      src_d   = '0;
      pc_d    = '0;
      tnew_d  = '0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = in_instr;
      src_d   = in_src;
      pc_d    = in_pc;
      tnew_d  = in_tnew;
    end else if (drain) begin
      valid_d = 1'b0;
      instr_d = '0;
    end else if (valid_q && tnew_q != '0) begin
      // Stalled entry: one cycle closer to producing its result.
      tnew_d = tnew_q - TNEW_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      src_q   <= '0;
      pc_q    <= '0;
      tnew_q  <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      src_q   <= src_d;
      pc_q    <= pc_d;
      tnew_q  <= tnew_d;
    end
  end

  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_src   = src_q;
  assign out_pc    = pc_q;
  assign out_tnew  = tnew_q;

  id_ex_decode u_decode (
    .instr   (instr_q),
    .valid   (valid_q),
    .alu_op  (alu_op),
    .alu_src (alu_src),
    .wb_addr (wb_addr),
    .wb_en   (wb_en)
  );

endmodule
